// File: rtl/ahbl_sram_responder.sv
// ahbl_sram_responder: AHB-Lite subordinate over a word-organised RAM, with
// programmable read/write wait states and the two-cycle ERROR response.
module ahbl_sram_responder #(
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32,
   parameter int DEPTH   = 1024,
   parameter int WAIT_RD = 0,
   parameter int WAIT_WR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ahbls_hready,
   output logic              ahbls_hready_resp,
   output logic              ahbls_hresp,
   input  logic [W_ADDR-1:0] ahbls_haddr,
   input  logic              ahbls_hwrite,
   input  logic [1:0]        ahbls_htrans,
   input  logic [2:0]        ahbls_hsize,
   input  logic [2:0]        ahbls_hburst,
   input  logic [3:0]        ahbls_hprot,
   input  logic              ahbls_hmastlock,
   input  logic [W_DATA-1:0] ahbls_hwdata,
   output logic [W_DATA-1:0] ahbls_hrdata
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [W_ADDR-1:0] LIMIT = W_ADDR'(4 * DEPTH);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_ERR1 = 3'd3;
   localparam logic [2:0] S_ERR2 = 3'd4;

   logic [2:0]        r_state, w_next;
   logic [3:0]        r_cnt, w_wait;
   logic [AW-1:0]     r_addr;
   logic              r_write;
   logic [3:0]        r_mask, w_mask;
   logic              w_open, w_accept, w_err;
   logic [W_DATA-1:0] w_lanes;
   logic [W_DATA-1:0] r_mem [DEPTH];
   logic              w_unused;

   assign w_unused = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

   // A new address phase can only be taken while our own data phase is not stalling
   assign w_open   = r_state != S_WAIT && r_state != S_ERR1;
   assign w_accept = w_open && ahbls_hready && ahbls_htrans[1];
   assign w_err    = ahbls_haddr >= LIMIT || ahbls_hsize > 3'd2 ||
                     (ahbls_hsize == 3'd1 && ahbls_haddr[0]) ||
                     (ahbls_hsize == 3'd2 && ahbls_haddr[1:0] != 2'b00);
   assign w_wait   = ahbls_hwrite ? 4'(WAIT_WR) : 4'(WAIT_RD);
   assign w_mask   = ahbls_hsize == 3'd0 ? 4'b0001 << ahbls_haddr[1:0] :
                     ahbls_hsize == 3'd1 ? (ahbls_haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign w_next   = r_state == S_WAIT ? (r_cnt == 4'd1 ? S_DATA : S_WAIT) :
                     r_state == S_ERR1 ? S_ERR2 :
                     !w_accept ? S_IDLE :
                     w_err ? S_ERR1 :
                     w_wait != 4'd0 ? S_WAIT : S_DATA;
   assign w_lanes  = {{8{r_mask[3]}}, {8{r_mask[2]}}, {8{r_mask[1]}}, {8{r_mask[0]}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_mask  <= 4'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= r_state == S_WAIT ? r_cnt - 4'd1 : (w_accept && !w_err) ? w_wait : 4'd0;
         if (w_accept) begin
            r_addr  <= ahbls_haddr[AW+1:2];
            r_write <= ahbls_hwrite;
            r_mask  <= w_mask;
         end
      end
   end

   // Array contents survive reset; only a completing write DATA cycle touches them
   always_ff @(posedge clk) begin
      if (r_state == S_DATA && r_write)
         for (int i = 0; i < 4; i++)
            if (r_mask[i]) r_mem[r_addr][8*i +: 8] <= ahbls_hwdata[8*i +: 8];
   end

   assign ahbls_hready_resp = w_open;
   assign ahbls_hresp       = r_state == S_ERR1 || r_state == S_ERR2;
   assign ahbls_hrdata      = (r_state == S_DATA && !r_write) ? r_mem[r_addr] & w_lanes : '0;

   a_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
      r_state == S_DATA |-> !$isunknown(r_addr));
   a_idle_ready: assert property (@(posedge clk) disable iff (!rst_n)
      r_state == S_IDLE |-> ahbls_hready_resp);
endmodule

// File: tb/tb_ahbl_sram_responder.sv
// tb_ahbl_sram_responder: directed bench; u0 has no wait states, u1 has
// WAIT_RD=3 / WAIT_WR=2. sel picks which one the bench is currently talking to.
module tb_ahbl_sram_responder;
   logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, ext_low = 1'b0;
   logic [31:0] haddr = '0, hwdata = '0;
   logic        hwrite = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [2:0]  hsize = 3'd2;
   logic [1:0]  htrans_0, htrans_1;
   logic        hready_0, hready_1, resp_0, resp_1, hresp_0, hresp_1;
   logic [31:0] rdata_0, rdata_1;
   logic        bus_rdy, bus_resp;
   logic [31:0] bus_rdata;
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   assign htrans_0  = sel ? 2'b00 : htrans;
   assign htrans_1  = sel ? htrans : 2'b00;
   assign hready_0  = resp_0 & ~ext_low;
   assign hready_1  = resp_1 & ~ext_low;
   assign bus_rdy   = sel ? hready_1 : hready_0;
   assign bus_resp  = sel ? hresp_1 : hresp_0;
   assign bus_rdata = sel ? rdata_1 : rdata_0;

   ahbl_sram_responder #(.DEPTH(1024), .WAIT_RD(0), .WAIT_WR(0)) u0 (
      .clk(clk), .rst_n(rst_n), .ahbls_hready(hready_0), .ahbls_hready_resp(resp_0),
      .ahbls_hresp(hresp_0), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans_0),
      .ahbls_hsize(hsize), .ahbls_hburst(3'd0), .ahbls_hprot(4'd0), .ahbls_hmastlock(1'b0),
      .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata_0));

   ahbl_sram_responder #(.DEPTH(1024), .WAIT_RD(3), .WAIT_WR(2)) u1 (
      .clk(clk), .rst_n(rst_n), .ahbls_hready(hready_1), .ahbls_hready_resp(resp_1),
      .ahbls_hresp(hresp_1), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans_1),
      .ahbls_hsize(hsize), .ahbls_hburst(3'd0), .ahbls_hprot(4'd0), .ahbls_hmastlock(1'b0),
      .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata_1));

   // Single isolated transfer, entered and left 1 time unit after a rising edge
   task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                       output logic rsp1, output int lows);
      haddr = a; hwrite = w; hsize = s; htrans = 2'b10;
      @(posedge clk);
      #1 htrans = 2'b00; hwdata = wd;
      lows = 0;
      @(negedge clk);
      rsp1 = bus_resp;
      while (!bus_rdy && lows < 40) begin
         lows++;
         @(negedge clk);
      end
      rd = bus_rdata; rsp = bus_resp;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10;
      #22;
      n_cmp++;
      if ({resp_0, hresp_0, rdata_0} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL reset_u0: got %b/%b/%h want 1/0/00000000", resp_0, hresp_0, rdata_0);
      end
      n_cmp++;
      if ({resp_1, hresp_1, rdata_1} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL reset_u1: got %b/%b/%h want 1/0/00000000", resp_1, hresp_1, rdata_1);
      end
      htrans = 2'b00; hwrite = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      @(posedge clk);
      #1 hwdata = 32'hDEADBEEF; hwrite = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus_rdy, bus_resp, bus_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL b2b_wr_phase: got %b/%b/%h want 1/0/00000000", bus_rdy, bus_resp, bus_rdata);
      end
      @(posedge clk);
      #1 htrans = 2'b00;
      @(negedge clk);
      n_cmp++;
      if ({bus_rdy, bus_resp, bus_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL b2b_rd_phase: got %b/%b/%h want 1/0/deadbeef", bus_rdy, bus_resp, bus_rdata);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++;
      if ({bus_rdy, bus_resp, bus_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL b2b_after: got %b/%b/%h want 1/0/00000000", bus_rdy, bus_resp, bus_rdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_lanes();
      logic [31:0] rd;
      logic        rsp, rsp1;
      int          lows;
      sel = 1'b0;
      xfer(32'h10, 1'b1, 3'd2, 32'h11223344, rd, rsp, rsp1, lows);
      xfer(32'h13, 1'b1, 3'd0, 32'hAA000000, rd, rsp, rsp1, lows);
      xfer(32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if ({rsp, lows[5:0], rd} !== {1'b0, 6'd0, 32'hAA223344}) begin
         n_err++; $display("FAIL byte_write: got resp %b waits %0d data %h want 0/0/aa223344", rsp, lows, rd);
      end
      xfer(32'h12, 1'b1, 3'd1, 32'h55660000, rd, rsp, rsp1, lows);
      xfer(32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if (rd !== 32'h55663344) begin
         n_err++; $display("FAIL half_write: got %h want 55663344", rd);
      end
      xfer(32'h11, 1'b0, 3'd0, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if (rd !== 32'h00003300) begin
         n_err++; $display("FAIL byte_read: got %h want 00003300", rd);
      end
      xfer(32'h12, 1'b0, 3'd1, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if (rd !== 32'h55660000) begin
         n_err++; $display("FAIL half_read: got %h want 55660000", rd);
      end
   endtask

   task automatic test_waits();
      logic [31:0] rd;
      logic        rsp, rsp1;
      int          lows;
      sel = 1'b1;
      xfer(32'h0, 1'b1, 3'd2, 32'hCAFEF00D, rd, rsp, rsp1, lows);
      n_cmp++;
      if (lows !== 2 || rsp !== 1'b0) begin
         n_err++; $display("FAIL wait_wr: got %0d low cycles resp %b want 2/0", lows, rsp);
      end
      xfer(32'h0, 1'b0, 3'd2, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if (lows !== 3 || rd !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL wait_rd: got %0d low cycles data %h want 3/cafef00d", lows, rd);
      end
      xfer(32'h1, 1'b0, 3'd0, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if (lows !== 3 || rd !== 32'h0000F000) begin
         n_err++; $display("FAIL wait_rd_byte: got %0d low cycles data %h want 3/0000f000", lows, rd);
      end
      sel = 1'b0;
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        rsp, rsp1;
      int          lows;
      logic [31:0] addrs [5] = '{32'h6, 32'h1000, 32'h5, 32'h4, 32'h1004};
      logic [2:0]  sizes [5] = '{3'd2, 3'd2, 3'd1, 3'd3, 3'd2};
      logic        wr    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      sel = 1'b0;
      xfer(32'h4, 1'b1, 3'd2, 32'h0BADC0DE, rd, rsp, rsp1, lows);
      for (int i = 0; i < 5; i++) begin
         xfer(addrs[i], wr[i], sizes[i], 32'hFFFFFFFF, rd, rsp, rsp1, lows);
         n_cmp++;
         if ({rsp1, rsp, rd} !== {1'b1, 1'b1, 32'h0} || lows !== 1) begin
            n_err++;
            $display("FAIL error_%0d: got first %b last %b waits %0d data %h want 1/1/1/00000000",
                     i, rsp1, rsp, lows, rd);
         end
      end
      xfer(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if ({rsp, rd} !== {1'b0, 32'h0BADC0DE} || lows !== 0) begin
         n_err++; $display("FAIL error_no_write: got resp %b waits %0d data %h want 0/0/0badc0de", rsp, lows, rd);
      end
   endtask

   task automatic test_idle_busy();
      logic [31:0] rd;
      logic        rsp, rsp1;
      int          lows;
      logic [31:0] exp [3] = '{32'h11111111, 32'h22222222, 32'h300000A8};
      sel = 1'b0;
      xfer(32'h30, 1'b1, 3'd2, 32'h300000A0, rd, rsp, rsp1, lows);
      xfer(32'h34, 1'b1, 3'd2, 32'h300000A4, rd, rsp, rsp1, lows);
      xfer(32'h38, 1'b1, 3'd2, 32'h300000A8, rd, rsp, rsp1, lows);
      haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b00;
      @(posedge clk);
      #1 htrans = 2'b01; haddr = 32'h34; hwdata = 32'h99999999;
      @(negedge clk);
      n_cmp++;
      if ({bus_rdy, bus_resp} !== 2'b10) begin
         n_err++; $display("FAIL idle_phase: got rdy %b resp %b want 1/0", bus_rdy, bus_resp);
      end
      @(posedge clk);
      #1 htrans = 2'b11; haddr = 32'h30;
      @(negedge clk);
      n_cmp++;
      if ({bus_rdy, bus_resp} !== 2'b10) begin
         n_err++; $display("FAIL busy_phase: got rdy %b resp %b want 1/0", bus_rdy, bus_resp);
      end
      @(posedge clk);
      #1 htrans = 2'b01; haddr = 32'h34; hwdata = 32'h11111111;
      @(posedge clk);
      #1 htrans = 2'b11; haddr = 32'h34; hwdata = 32'hEEEEEEEE;
      @(posedge clk);
      #1 htrans = 2'b00; hwdata = 32'h22222222;
      @(posedge clk);
      #1 ext_low = 1'b1; htrans = 2'b10; hwdata = 32'h77777777;
      for (int i = 0; i < 4; i++) begin
         haddr = (i % 2 == 0) ? 32'h38 : 32'h30;
         @(negedge clk);
         n_cmp++;
         if ({resp_0, hresp_0, rdata_0} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL ext_stall_%0d: got %b/%b/%h want 1/0/00000000", i, resp_0, hresp_0, rdata_0);
         end
         @(posedge clk);
         #1;
      end
      ext_low = 1'b0; htrans = 2'b00; hwdata = '0;
      for (int i = 0; i < 3; i++) begin
         xfer(32'h30 + 32'(4 * i), 1'b0, 3'd2, 32'h0, rd, rsp, rsp1, lows);
         n_cmp++;
         if (rd !== exp[i]) begin
            n_err++; $display("FAIL idle_busy_mem_%0d: got %h want %h", i, rd, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        rsp, rsp1;
      int          lows;
      sel = 1'b1;
      xfer(32'h20, 1'b1, 3'd2, 32'h12345678, rd, rsp, rsp1, lows);
      haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      @(posedge clk);
      #1 htrans = 2'b00; hwdata = 32'h87654321;
      @(negedge clk);
      n_cmp++;
      if (resp_1 !== 1'b0) begin
         n_err++; $display("FAIL mid_wait: got hready_resp %b want 0", resp_1);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({resp_1, hresp_1, rdata_1} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL mid_reset: got %b/%b/%h want 1/0/00000000", resp_1, hresp_1, rdata_1);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      xfer(32'h20, 1'b0, 3'd2, 32'h0, rd, rsp, rsp1, lows);
      n_cmp++;
      if (rd !== 32'h12345678 || lows !== 3) begin
         n_err++; $display("FAIL mid_no_commit: got %h waits %0d want 12345678/3", rd, lows);
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_lanes();
      test_waits();
      test_errors();
      test_idle_busy();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
